// File: rtl/if_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction memory combinationally
// and fills the IF/ID register, with start, stall, branch redirect and halt handling.
module if_sequencer #(
  parameter logic [7:0]  RESET_PC  = 8'd0,
  parameter logic [31:0] HALT_WORD = 32'hFC000000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [7:0]       BranchTarget,
  output logic [7:0]       Address,
  input  logic [31:0]      InstructionIn,
  output logic [31:0]      IFIDInstr,
  output logic [7:0]       IFIDPC,
  output logic             IFIDValid,
  output logic             Halted,
  output logic             Wrapped,
  output logic [CNT_W-1:0] FetchCount
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } state_e;

  // Word alignment is enforced even if RESET_PC is misaligned.
  localparam logic [7:0] StartPc = {RESET_PC[7:2], 2'b00};
  localparam logic [7:0] LastPc  = 8'd252;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [7:0]       ifid_pc_q, ifid_pc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             wrapped_q, wrapped_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic             is_halt_word;
  logic             count_full;

  assign is_halt_word = (InstructionIn == HALT_WORD);
  assign count_full   = (fetch_count_q == {CNT_W{1'b1}});

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    wrapped_d     = wrapped_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      StIdle: begin
        ifid_valid_d = 1'b0;
        if (Start) begin
          pc_d    = StartPc;
          state_d = StFetch;
        end
      end

      StFetch: begin
        if (BranchTaken) begin
          // Redirect beats both stall and a halt word; leaves one bubble.
          pc_d         = {BranchTarget[7:2], 2'b00};
          ifid_valid_d = 1'b0;
        end else if (Stall) begin
          // Hold everything.
        end else if (is_halt_word) begin
          ifid_valid_d = 1'b0;
          state_d      = StHalt;
        end else begin
          ifid_instr_d = InstructionIn;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 8'd4;
          if (pc_q == LastPc) begin
            wrapped_d = 1'b1;
          end
          if (!count_full) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
          end
        end
      end

      StHalt: begin
        ifid_valid_d = 1'b0;
        if (Start) begin
          pc_d    = StartPc;
          state_d = StFetch;
        end
      end

      default: begin
        state_d      = StIdle;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= StartPc;
      ifid_instr_q  <= 32'd0;
      ifid_pc_q     <= 8'd0;
      ifid_valid_q  <= 1'b0;
      wrapped_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      wrapped_q     <= wrapped_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign Address    = pc_q;
  assign IFIDInstr  = ifid_instr_q;
  assign IFIDPC     = ifid_pc_q;
  assign IFIDValid  = ifid_valid_q;
  assign Halted     = (state_q == StHalt);
  assign Wrapped    = wrapped_q;
  assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_if_sequencer.sv
// Directed bench for if_sequencer: fetch, stall, redirect, halt, wrap, async reset, saturation.
module tb_if_sequencer;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        Stall;
  logic        BranchTaken;
  logic [7:0]  BranchTarget;
  logic [7:0]  Address;
  logic [31:0] InstructionIn;
  logic [31:0] IFIDInstr;
  logic [7:0]  IFIDPC;
  logic        IFIDValid;
  logic        Halted;
  logic        Wrapped;
  logic [15:0] FetchCount;

  logic [31:0] im [0:63];
  int tests;
  int fails;

  if_sequencer #(
    .RESET_PC (8'd0),
    .HALT_WORD(32'hFC000000),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Start        (Start),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Address      (Address),
    .InstructionIn(InstructionIn),
    .IFIDInstr    (IFIDInstr),
    .IFIDPC       (IFIDPC),
    .IFIDValid    (IFIDValid),
    .Halted       (Halted),
    .Wrapped      (Wrapped),
    .FetchCount   (FetchCount)
  );

  assign InstructionIn = im[Address[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) im[i] = 32'h1000_0000 + i;
    im[0]  = 32'h8C050014;
    im[1]  = 32'h8C0A0014;
    im[2]  = 32'h00A55820;
    im[6]  = 32'h01095020;
    im[7]  = 32'h8C0B0018;
    im[8]  = 32'hFC000000;
    im[10] = 32'hAC0B0030;

    rst_n = 1'b0; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 8'd0;
    #2;
    check("rst_addr", Address, 0);
    check("rst_instr", IFIDInstr, 0);
    check("rst_pc", IFIDPC, 0);
    check("rst_valid", IFIDValid, 0);
    check("rst_halted", Halted, 0);
    check("rst_wrapped", Wrapped, 0);
    check("rst_count", FetchCount, 0);
    tick();
    rst_n = 1'b1;

    // Stall and branch in IDLE are ignored
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 8'd40;
    tick();
    check("idle_addr", Address, 0);
    check("idle_valid", IFIDValid, 0);
    Stall = 1'b0; BranchTaken = 1'b0;

    // Start and first two fetches
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_addr", Address, 0);
    check("start_valid", IFIDValid, 0);
    tick();
    check("f0_instr", IFIDInstr, 32'h8C050014);
    check("f0_pc", IFIDPC, 0);
    check("f0_valid", IFIDValid, 1);
    check("f0_addr", Address, 4);
    tick();
    check("f1_instr", IFIDInstr, 32'h8C0A0014);
    check("f1_pc", IFIDPC, 4);
    check("f1_count", FetchCount, 2);
    check("f1_addr", Address, 8);

    // Stall three cycles at PC=8
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", Address, 8);
      check("stall_instr", IFIDInstr, 32'h8C0A0014);
      check("stall_pc", IFIDPC, 4);
      check("stall_valid", IFIDValid, 1);
      check("stall_count", FetchCount, 2);
    end
    Stall = 1'b0;
    tick();
    check("unstall_instr", IFIDInstr, 32'h00A55820);
    check("unstall_pc", IFIDPC, 8);
    check("unstall_count", FetchCount, 3);
    check("unstall_addr", Address, 12);

    // Branch overrides stall, target bits [1:0] dropped
    BranchTaken = 1'b1; BranchTarget = 8'd27; Stall = 1'b1;
    tick();
    BranchTaken = 1'b0; Stall = 1'b0;
    check("br_addr", Address, 24);
    check("br_valid", IFIDValid, 0);
    check("br_pc_hold", IFIDPC, 8);
    check("br_count", FetchCount, 3);
    tick();
    check("br_instr", IFIDInstr, 32'h01095020);
    check("br_tgt_pc", IFIDPC, 24);
    check("br_tgt_count", FetchCount, 4);

    // Halt word at 32
    tick();
    check("pre_halt_instr", IFIDInstr, 32'h8C0B0018);
    check("pre_halt_count", FetchCount, 5);
    check("pre_halt_addr", Address, 32);
    tick();
    check("halt_halted", Halted, 1);
    check("halt_addr", Address, 32);
    check("halt_valid", IFIDValid, 0);
    check("halt_count", FetchCount, 5);
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 8'd40;
    tick();
    Stall = 1'b0; BranchTaken = 1'b0;
    check("halt_ign_halted", Halted, 1);
    check("halt_ign_addr", Address, 32);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("restart_halted", Halted, 0);
    check("restart_addr", Address, 0);
    check("restart_valid", IFIDValid, 0);
    check("restart_count", FetchCount, 5);

    // Branch into the halt word, then redirect while it is presented
    tick();
    check("refetch_instr", IFIDInstr, 32'h8C050014);
    check("refetch_count", FetchCount, 6);
    BranchTaken = 1'b1; BranchTarget = 8'd32;
    tick();
    check("br32_addr", Address, 32);
    BranchTarget = 8'd40;
    tick();
    BranchTaken = 1'b0;
    check("br_vs_halt_halted", Halted, 0);
    check("br_vs_halt_addr", Address, 40);
    check("br_vs_halt_valid", IFIDValid, 0);
    tick();
    check("br40_instr", IFIDInstr, 32'hAC0B0030);
    check("br40_pc", IFIDPC, 40);
    check("br40_count", FetchCount, 7);
    check("br40_addr", Address, 44);

    // Run to the wrap
    im[8] = 32'h1000_0008;
    for (int i = 0; i < 52; i++) tick();
    check("prewrap_addr", Address, 252);
    check("prewrap_wrapped", Wrapped, 0);
    check("prewrap_count", FetchCount, 59);
    tick();
    check("wrap_addr", Address, 0);
    check("wrap_wrapped", Wrapped, 1);
    check("wrap_count", FetchCount, 60);
    check("wrap_pc", IFIDPC, 252);
    tick();
    check("wrap_sticky", Wrapped, 1);
    check("wrap_addr2", Address, 4);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_addr", Address, 0);
    check("arst_instr", IFIDInstr, 0);
    check("arst_pc", IFIDPC, 0);
    check("arst_valid", IFIDValid, 0);
    check("arst_wrapped", Wrapped, 0);
    check("arst_count", FetchCount, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_idle_valid", IFIDValid, 0);
    check("arst_idle_count", FetchCount, 0);
    check("arst_idle_addr", Address, 0);

    // Counter saturation
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    check("sat_reach", FetchCount, 32'h0000FFFF);
    tick();
    check("sat_hold", FetchCount, 32'h0000FFFF);
    check("sat_valid", IFIDValid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
